// File: rtl/pwm_pkg.sv
// Shared PWM definitions: counter width default, saturation value and FSM states.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF = 18;
    localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_sync.sv
// Synchronizer plus history flop for an asynchronous PWM input.
// Rise and fall events see the same pipeline depth, so measured widths are unskewed.
module pwm_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   w_armed;
    logic                   w_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Events stay masked until the pipeline holds real samples, so an input
    // already high at reset release is not mistaken for a rising edge.
    assign w_armed  = r_fill[SYNC_STAGES];
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign o_level  = w_sync;
    assign o_rise_c = w_armed &  w_sync & ~r_hist;
    assign o_fall_c = w_armed & ~w_sync &  r_hist;

endmodule : pwm_sync

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clock cycles,
// with a sticky timeout when no complete period arrives before the counter saturates.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             in_10Mhz,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] SAT     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pwm_state_e       r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [CNT_W-1:0] r_hi,     w_hi_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic [CNT_W-1:0] r_high,   w_high_nxt;
    logic             r_valid,  w_valid_nxt;
    logic             r_tout,   w_tout_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_sat;

    pwm_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (in_10Mhz),
        .rst_n    (reset),
        .i_async  (pwm_in),
        .o_level  (level),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    assign w_sat = (r_cnt == SAT);

    always_ff @(posedge in_10Mhz or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_valid  <= w_valid_nxt;
            r_tout   <= w_tout_nxt;
        end
    end

    // Counter reads k in the k-th cycle after a rise event, so a fall after H
    // cycles latches H and the next rise after P cycles captures P.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_valid_nxt  = 1'b0;
        w_tout_nxt   = r_tout;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (w_sat) begin
                    w_state_nxt = ST_IDLE;
                    w_tout_nxt  = 1'b1;
                end else if (w_rise) begin
                    w_cnt_nxt = CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (w_fall) begin
                        w_hi_nxt    = r_cnt;
                        w_state_nxt = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt  = ST_HIGH;
                    w_cnt_nxt    = CNT_ONE;
                    w_period_nxt = r_cnt;
                    w_high_nxt   = r_hi;
                    w_valid_nxt  = 1'b1;
                    w_tout_nxt   = 1'b0;
                end else if (w_sat) begin
                    w_state_nxt = ST_IDLE;
                    w_tout_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_valid;
    assign timeout    = r_tout;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture; a narrower counter keeps saturation runs short.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int unsigned CNT_W = 12;
    localparam int          SAT   = 4095;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             level;

    int   checks = 0;
    int   errors = 0;
    int   phase  = 50;
    logic mv_prev = 1'b0;
    int   q_p[$];
    int   q_h[$];
    int   hs[12];

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .in_10Mhz   (clk),
        .reset      (rst_n),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .level      (level)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Record every measurement; back-to-back pulses are an error on their own.
    always @(negedge clk) begin
        if (meas_valid) begin
            chk("mv_gap", int'(mv_prev), 0);
            q_p.push_back(int'(period));
            q_h.push_back(int'(high_time));
        end
        mv_prev <= meas_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #(phase);
    endtask

    task automatic gen(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            wait_cyc(h);
            pwm_in = 1'b0;
            wait_cyc(p - h);
        end
    endtask

    task automatic expect_meas(input string tag, input int n, input int p, input int h);
        int gp, gh;
        for (int i = 0; i < n; i++) begin
            if (q_p.size() == 0) begin
                chk({tag, "_count"}, i, n);
                break;
            end
            gp = q_p.pop_front();
            gh = q_h.pop_front();
            chk({tag, "_period"}, gp, p);
            chk({tag, "_high"}, gh, h);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #10;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        q_p.delete();
        q_h.delete();
        phase = int'($urandom_range(5, 95));
        #(phase);
    endtask

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        #120;
        chk("rst_period", int'(period), 0);
        chk("rst_high", int'(high_time), 0);
        chk("rst_mv", int'(meas_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_level", int'(level), 0);

        // Nominal 1000/250: first rise only starts counting.
        do_reset();
        gen(1000, 250, 4);
        expect_meas("A", 3, 1000, 250);
        chk("A_left", q_p.size(), 0);
        chk("A_timeout", int'(timeout), 0);

        // Narrow pulses, then the 2-cycle minimum period back to back.
        do_reset();
        gen(10, 3, 5);
        expect_meas("B", 4, 10, 3);
        chk("B_left", q_p.size(), 0);
        gen(2, 1, 6);
        wait_cyc(6);
        expect_meas("C0", 1, 10, 3);
        expect_meas("C", 5, 2, 1);
        chk("C_left", q_p.size(), 0);

        // Held low after a measurement: timeout SAT cycles after the last load.
        do_reset();
        gen(1000, 250, 3);
        pwm_in = 1'b1;
        wait_cyc(250);
        pwm_in = 1'b0;
        wait_cyc(SAT + 2 - 250);
        chk("D0_to_early", int'(timeout), 0);
        wait_cyc(1);
        chk("D0_to", int'(timeout), 1);
        chk("D0_period", int'(period), 1000);
        chk("D0_high", int'(high_time), 250);
        chk("D0_level", int'(level), 0);
        expect_meas("D0", 3, 1000, 250);
        chk("D0_left", q_p.size(), 0);

        // Resume after timeout: first rise silent, second clears timeout.
        gen(500, 100, 2);
        chk("D1_to_clr", int'(timeout), 0);
        expect_meas("D1", 1, 500, 100);
        chk("D1_left", q_p.size(), 0);

        // Held high: timeout from HIGH.
        pwm_in = 1'b1;
        wait_cyc(SAT + 2);
        chk("D2_to_early", int'(timeout), 0);
        wait_cyc(1);
        chk("D2_to", int'(timeout), 1);
        chk("D2_period", int'(period), 500);
        chk("D2_high", int'(high_time), 100);
        chk("D2_level", int'(level), 1);
        expect_meas("D2", 1, 500, 100);
        chk("D2_left", q_p.size(), 0);

        // Reset mid-high for 37 cycles while the waveform keeps running.
        do_reset();
        gen(1000, 250, 2);
        pwm_in = 1'b1;
        wait_cyc(125);
        rst_n = 1'b0;
        wait_cyc(1);
        chk("E_rst_period", int'(period), 0);
        chk("E_rst_high", int'(high_time), 0);
        chk("E_rst_mv", int'(meas_valid), 0);
        chk("E_rst_timeout", int'(timeout), 0);
        chk("E_rst_level", int'(level), 0);
        expect_meas("E0", 2, 1000, 250);
        chk("E0_left", q_p.size(), 0);
        wait_cyc(36);
        rst_n = 1'b1;
        wait_cyc(88);
        pwm_in = 1'b0;
        wait_cyc(750);
        chk("E_norise", q_p.size(), 0);
        gen(1000, 250, 2);
        expect_meas("E1", 1, 1000, 250);
        chk("E1_left", q_p.size(), 0);

        // Duty sweep at period 1000, fresh random phase each point.
        hs = '{1, 2, 3, 250, 499, 500, 501, 997, 998, 999, 0, 0};
        hs[10] = int'($urandom_range(4, 996));
        hs[11] = int'($urandom_range(4, 996));
        for (int i = 0; i < 12; i++) begin
            do_reset();
            gen(1000, hs[i], 2);
            expect_meas($sformatf("SW%0d", hs[i]), 1, 1000, hs[i]);
            chk($sformatf("SW%0d_left", hs[i]), q_p.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pwm_capture

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 18, width of the period/high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on pwm_in (minimum 2).
REQ-003 in_10Mhz  input  1  sole clock, all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pwm_in  input  1  PWM waveform to be measured, asynchronous to in_10Mhz.
REQ-006 period  output  CNT_W  clock cycles from one rising edge of pwm_in to the next, last valid measurement.
REQ-007 high_time  output  CNT_W  clock cycles pwm_in was high within that period.
REQ-008 meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 timeout  output  1  no complete period seen within 2^CNT_W-1 cycles.
REQ-010 level  output  1  synchronized pwm_in level.

Function
REQ-011 pwm_in shall pass through SYNC_STAGES flops, then one history flop; rise_evt = sync & ~hist, fall_evt = ~sync & hist.
REQ-012 Latency shall be fixed: an input edge produces its event SYNC_STAGES+1 cycles later, with equal delay for rises and falls, so measured widths are not skewed.
REQ-013 FSM states shall be IDLE, HIGH and LOW; the reset state shall be IDLE.
REQ-014 IDLE: rise_evt -> HIGH, counter loaded with 1, no meas_valid; fall_evt ignored.
REQ-015 HIGH: counter increments each cycle; fall_evt -> LOW, hi_latch <= counter.
REQ-016 LOW: counter increments; rise_evt -> HIGH, period <= counter, high_time <= hi_latch, meas_valid = 1 next cycle, timeout cleared, counter reloaded with 1.
REQ-017 The counting rule shall give period = P and high_time = H for a waveform that rises every P cycles and stays high H cycles (1 <= H < P).
REQ-018 rise_evt in HIGH cannot occur by construction; the FSM shall treat it as a restart (counter <= 1, stay HIGH, no meas_valid).
REQ-019 Counter shall saturate at 2^CNT_W-1; on reaching it in HIGH or LOW, the FSM shall enter IDLE and set timeout, and period/high_time shall hold their last values.
REQ-020 timeout shall stay sticky until the next meas_valid or reset.
REQ-021 After a timeout, the next rise_evt shall start a fresh measurement; the first period after IDLE never produces meas_valid.
REQ-022 meas_valid shall never be high two consecutive cycles; the minimum spacing between pulses shall be 2 cycles.
REQ-023 level shall equal the synchronized value (sync flop output).

Reset
REQ-024 While reset = 0, all flops including synchronizers shall clear asynchronously: period=0, high_time=0, meas_valid=0, timeout=0, level=0, FSM=IDLE, counter=0.
REQ-025 Reset asserted mid-measurement shall discard the partial measurement; after release, a full rise-to-rise period is required before meas_valid.

Structure
REQ-026 Shared package pwm_pkg shall hold the CNT_W default (18), the counter saturation constant and the FSM state enumeration (shared with PWM generator work).
REQ-027 One sub-module, pwm_sync (synchronizer + edge detector, outputs sync level, rise_evt, fall_evt), shall be instantiated; the counter and FSM shall stay in pwm_capture.

Verification
REQ-028 Run a 10 MHz clock with pwm_in period 1000 cycles, high 250 -> from the second rising edge on, meas_valid every 1000 cycles with period=1000 and high_time=250.
REQ-029 Narrow pulse: period 10, high 3 -> period=10, high_time=3 on every pulse; then period 2, high 1 -> period=2, high_time=1.
REQ-030 Hold pwm_in constant 0 (then constant 1) after a valid measurement -> timeout=1 exactly 262143 cycles after the last counter load, period/high_time unchanged, no meas_valid.
REQ-031 After a timeout, resume period 500, high 100 -> first rise gives no pulse; second rise gives meas_valid, period=500, high_time=100, timeout=0.
REQ-032 Assert reset at mid-high of a period-1000 waveform, release 37 cycles later -> all outputs 0 during reset; first meas_valid only after two post-reset rises, values 1000/250.
REQ-033 Duty sweep with high = 1..999 at period 1000, random phase relative to in_10Mhz -> every measurement exact.
